// File: rtl/bcd_count_ctrl_pkg.sv
// Shared definitions for the 2-digit BCD run/pause/clear counter controller.
//   state_t    : controller FSM encoding (IDLE/RUN/PAUSE/DONE)
//   DIGIT_MAX  : highest BCD digit value (9)
//   DIGIT_MIN  : lowest BCD digit value (0)
//   sat_digit  : clamps a raw nibble to a legal BCD digit
package bcd_count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] DIGIT_MIN = 4'd0;

  // Preset nibbles above 9 are not BCD; clamp them to 9.
  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_digit.sv
// Single 0-9 BCD digit stage with synchronous load and up/down stepping.
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset, digit -> 0
//   en      : step this cycle
//   dn      : 0 = count up, 1 = count down
//   ld      : load ld_val this cycle (overrides en)
//   ld_val  : value to load (already a legal digit)
//   q       : registered digit value
//   cy      : carry (9->0 up) / borrow (0->9 down) out, combinational
module bcd_digit
  import bcd_count_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dn,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       cy
);

  assign cy = en & (dn ? (q == DIGIT_MIN) : (q == DIGIT_MAX));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the always blocks execute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= DIGIT_MIN;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      if (dn) q <= (q == DIGIT_MIN) ? DIGIT_MAX : q - 4'd1;
      else    q <= (q == DIGIT_MAX) ? DIGIT_MIN : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear controller for a 2-digit BCD counter (00-99).
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset, clears all state
//   start    : pulse, run / resume / restart
//   stop     : pulse, pause (wins over start)
//   clear    : pulse, digits -> 00 and back to IDLE (highest priority)
//   load     : pulse, preset digits from load_val (not in RUN)
//   load_val : BCD preset {tens, ones}, nibbles >9 saturate to 9
//   dir      : 0 = count up, 1 = count down
//   oneshot  : 1 = stop at terminal count, 0 = wrap around
//   ones     : units digit
//   tens     : tens digit
//   running  : FSM is in RUN
//   done     : FSM is in DONE
//   tick     : one-cycle pulse in the cycle a count step is taken
//   wrap     : one-cycle pulse when the count wraps 99->00 or 00->99
module bcd_count_ctrl
  import bcd_count_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned PRE_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dir,
  input  logic       oneshot,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       done,
  output logic       tick,
  output logic       wrap
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             ld;
  logic [3:0]       ld_ones, ld_tens;
  logic             at_term, hold_term, step_en;
  logic             ones_cy, tens_cy;

  assign at_term   = dir ? ((ones == DIGIT_MIN) && (tens == DIGIT_MIN))
                         : ((ones == DIGIT_MAX) && (tens == DIGIT_MAX));
  assign hold_term = oneshot & at_term;
  assign tick      = (state_q == RUN) && (pre_q == PRE_MAX);
  // In one-shot mode the terminal tick must not move the digits.
  assign step_en   = tick & ~hold_term;
  // Tens only carries out when both digits roll over on a real step, which is
  // exactly a wrap; in one-shot mode the step is suppressed so no pulse.
  assign wrap      = tens_cy;
  assign running   = (state_q == RUN);
  assign done      = (state_q == DONE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    state_d = state_q;
    ld      = 1'b0;
    ld_ones = DIGIT_MIN;
    ld_tens = DIGIT_MIN;
    case (state_q)
      RUN:     pre_d = tick ? '0 : pre_q + PRE_W'(1);
      PAUSE:   pre_d = pre_q;
      default: pre_d = '0;
    endcase

    if (clear) begin
      state_d = IDLE;
      pre_d   = '0;
      ld      = 1'b1;
    end else if (state_q == RUN) begin
      // load and start are ignored while running.
      if (stop)                   state_d = PAUSE;
      else if (tick && hold_term) state_d = DONE;
    end else if (load) begin
      ld      = 1'b1;
      ld_ones = sat_digit(load_val[3:0]);
      ld_tens = sat_digit(load_val[7:4]);
      if (state_q == DONE) state_d = IDLE;
    end else if (start && !stop) begin
      state_d = RUN;
      // Restart from DONE begins at the count origin for the current direction;
      // the prescaler is already zero in DONE and held in PAUSE.
      if (state_q == DONE) begin
        ld      = 1'b1;
        ld_ones = dir ? DIGIT_MAX : DIGIT_MIN;
        ld_tens = dir ? DIGIT_MAX : DIGIT_MIN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
    end
  end

  bcd_digit u_ones (
    .clk    (clk),
    .reset  (reset),
    .en     (step_en),
    .dn     (dir),
    .ld     (ld),
    .ld_val (ld_ones),
    .q      (ones),
    .cy     (ones_cy)
  );

  bcd_digit u_tens (
    .clk    (clk),
    .reset  (reset),
    .en     (ones_cy),
    .dn     (dir),
    .ld     (ld),
    .ld_val (ld_tens),
    .q      (tens),
    .cy     (tens_cy)
  );

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl with TICK_DIV = 4.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge, so each vector's expectation is the state after that edge.
module tb_bcd_count_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, clear, load;
  logic [7:0] load_val;
  logic       dir, oneshot;
  logic [3:0] ones, tens;
  logic       running, done, tick, wrap;

  always #5 clk = ~clk;

  bcd_count_ctrl #(.TICK_DIV(4), .PRE_W(26)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .oneshot  (oneshot),
    .ones     (ones),
    .tens     (tens),
    .running  (running),
    .done     (done),
    .tick     (tick),
    .wrap     (wrap)
  );

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;
    logic       tick;
    logic       wrap;
  } out_t;

  // Command bits: {clear, load, stop, start}
  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_LOAD  = 4'b0100;
  localparam logic [3:0] C_CLEAR = 4'b1000;

  typedef struct {
    logic [3:0] cmd;
    logic [7:0] lv;
    out_t       exp;
    string      name;
  } vec_t;

  typedef struct {
    out_t  exp;
    string name;
  } sb_t;

  vec_t tbl[13];
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic out_t o(input int t, input int n, input bit r,
                             input bit d, input bit tk, input bit w);
    out_t v;
    v.tens    = 4'(t);
    v.ones    = 4'(n);
    v.running = r;
    v.done    = d;
    v.tick    = tk;
    v.wrap    = w;
    return v;
  endfunction

  function automatic out_t sample();
    out_t v;
    v.tens    = tens;
    v.ones    = ones;
    v.running = running;
    v.done    = done;
    v.tick    = tick;
    v.wrap    = wrap;
    return v;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got tens=%0d ones=%0d run=%b done=%b tick=%b wrap=%b, expected tens=%0d ones=%0d run=%b done=%b tick=%b wrap=%b",
               name, act.tens, act.ones, act.running, act.done, act.tick, act.wrap,
               exp.tens, exp.ones, exp.running, exp.done, exp.tick, exp.wrap);
    end
  endtask

  // Compare the oldest scoreboard entry against the DUT right now.
  task automatic sb_compare();
    sb_t s;
    s = sb_q.pop_front();
    check(s.name, sample(), s.exp);
  endtask

  task automatic apply(input logic [3:0] c, input logic [7:0] lv,
                       input out_t e, input string nm);
    @(negedge clk);
    {clear, load, stop, start} = c;
    load_val = lv;
    sb_q.push_back('{exp: e, name: nm});
    @(posedge clk);
    #1;
    sb_compare();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      {clear, load, stop, start} = C_NONE;
      @(posedge clk);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    {clear, load, stop, start} = C_NONE;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    sb_q.push_back('{exp: o(0, 0, 0, 0, 0, 0), name: nm});
    sb_compare();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    {clear, load, stop, start} = C_NONE;
    load_val = 8'h00;
    dir      = 1'b0;
    oneshot  = 1'b0;

    // 1. Basic up count: step at edges 4/8/12 after start, tick the cycle before.
    tbl[0] = '{cmd: C_START, lv: 8'h00, exp: o(0, 0, 1, 0, 0, 0), name: "t1_start"};
    for (int i = 1; i < 13; i++)
      tbl[i] = '{cmd: C_NONE, lv: 8'h00,
                 exp: o(0, i / 4, 1, 0, (i % 4) == 3, 0), name: $sformatf("t1_cyc%0d", i)};

    do_reset("t1_reset");
    for (int i = 0; i < 13; i++) apply(tbl[i].cmd, tbl[i].lv, tbl[i].exp, tbl[i].name);

    // 2. Wrap mode up: 98 -> 99 -> 00 with a single wrap pulse.
    do_reset("t2_reset");
    apply(C_LOAD,  8'h98, o(9, 8, 0, 0, 0, 0), "t2_load98");
    apply(C_START, 8'h00, o(9, 8, 1, 0, 0, 0), "t2_start");
    idle(2);
    apply(C_NONE,  8'h00, o(9, 8, 1, 0, 1, 0), "t2_tick98");
    apply(C_NONE,  8'h00, o(9, 9, 1, 0, 0, 0), "t2_at99");
    idle(2);
    apply(C_NONE,  8'h00, o(9, 9, 1, 0, 1, 1), "t2_wrap_pulse");
    apply(C_NONE,  8'h00, o(0, 0, 1, 0, 0, 0), "t2_at00");
    idle(2);
    apply(C_NONE,  8'h00, o(0, 0, 1, 0, 1, 0), "t2_no_second_wrap");

    // 3. One-shot up: stop at 99 in DONE, hold, restart from 00.
    oneshot = 1'b1;
    do_reset("t3_reset");
    apply(C_LOAD,  8'h98, o(9, 8, 0, 0, 0, 0), "t3_load98");
    apply(C_START, 8'h00, o(9, 8, 1, 0, 0, 0), "t3_start");
    idle(2);
    apply(C_NONE,  8'h00, o(9, 8, 1, 0, 1, 0), "t3_tick98");
    apply(C_NONE,  8'h00, o(9, 9, 1, 0, 0, 0), "t3_at99");
    idle(2);
    apply(C_NONE,  8'h00, o(9, 9, 1, 0, 1, 0), "t3_term_tick_no_wrap");
    apply(C_NONE,  8'h00, o(9, 9, 0, 1, 0, 0), "t3_done");
    idle(20);
    apply(C_NONE,  8'h00, o(9, 9, 0, 1, 0, 0), "t3_done_hold");
    apply(C_START, 8'h00, o(0, 0, 1, 0, 0, 0), "t3_restart_00");

    // 4. Pause keeps the prescaler; start+stop in RUN pauses.
    oneshot = 1'b0;
    do_reset("t4_reset");
    apply(C_START, 8'h00, o(0, 0, 1, 0, 0, 0), "t4_start");
    apply(C_NONE,  8'h00, o(0, 0, 1, 0, 0, 0), "t4_run1");
    apply(C_STOP,  8'h00, o(0, 0, 0, 0, 0, 0), "t4_pause");
    idle(10);
    apply(C_NONE,  8'h00, o(0, 0, 0, 0, 0, 0), "t4_paused_hold");
    apply(C_START, 8'h00, o(0, 0, 1, 0, 0, 0), "t4_resume");
    apply(C_NONE,  8'h00, o(0, 0, 1, 0, 1, 0), "t4_resume_tick");
    apply(C_NONE,  8'h00, o(0, 1, 1, 0, 0, 0), "t4_resume_step");
    apply(C_START | C_STOP, 8'h00, o(0, 1, 0, 0, 0, 0), "t4_start_stop");

    // 5. Down count wraps 00 -> 99; load ignored in RUN, saturates in PAUSE.
    dir = 1'b1;
    do_reset("t5_reset");
    apply(C_START, 8'h00, o(0, 0, 1, 0, 0, 0), "t5_start");
    idle(2);
    apply(C_NONE,  8'h00, o(0, 0, 1, 0, 1, 1), "t5_down_wrap");
    apply(C_NONE,  8'h00, o(9, 9, 1, 0, 0, 0), "t5_at99");
    apply(C_LOAD,  8'h55, o(9, 9, 1, 0, 0, 0), "t5_load_in_run");
    apply(C_STOP,  8'h00, o(9, 9, 0, 0, 0, 0), "t5_pause");
    apply(C_LOAD,  8'h12, o(1, 2, 0, 0, 0, 0), "t5_load12_pause");
    apply(C_LOAD,  8'hAF, o(9, 9, 0, 0, 0, 0), "t5_load_sat");
    apply(C_START, 8'h00, o(9, 9, 1, 0, 0, 0), "t5_resume");
    apply(C_NONE,  8'h00, o(9, 9, 1, 0, 1, 0), "t5_tick99");
    apply(C_NONE,  8'h00, o(9, 8, 1, 0, 0, 0), "t5_down_step");

    // 6. Asynchronous reset mid-count; clear beats load.
    dir = 1'b0;
    do_reset("t6_reset");
    apply(C_LOAD,  8'h57, o(5, 7, 0, 0, 0, 0), "t6_load57");
    apply(C_START, 8'h00, o(5, 7, 1, 0, 0, 0), "t6_start");
    idle(2);
    apply(C_NONE,  8'h00, o(5, 7, 1, 0, 1, 0), "t6_tick57");
    @(negedge clk);
    {clear, load, stop, start} = C_NONE;
    #2;
    reset = 1'b1;
    #1;
    sb_q.push_back('{exp: o(0, 0, 0, 0, 0, 0), name: "t6_async_reset"});
    sb_compare();
    @(negedge clk);
    reset = 1'b0;
    apply(C_LOAD,  8'h34, o(3, 4, 0, 0, 0, 0), "t6_load34");
    apply(C_START, 8'h00, o(3, 4, 1, 0, 0, 0), "t6_start2");
    apply(C_CLEAR | C_LOAD, 8'h77, o(0, 0, 0, 0, 0, 0), "t6_clear_load");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
